// File: rtl/wave_display_multi.sv
// Multi-channel wave display pixel generator: renders CHANNELS sample traces into one
// window with line/dot/fill modes; buffer select and mode are latched at frame start.
module wave_display_multi #(
    parameter int unsigned              CHANNELS = 2,
    parameter int unsigned              ADDR_W   = 8,
    parameter int unsigned              SAMPLE_W = 8,
    parameter int unsigned              X_START  = 256,
    parameter logic [CHANNELS*24-1:0]   COLORS   = {24'hFFFF00, 24'h00FFFF}
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid,
    input  logic                               frame_start,
    input  logic                               read_index,
    input  logic [1:0]                         mode,
    input  logic [10:0]                        x,
    input  logic [9:0]                         y,
    input  logic [CHANNELS*SAMPLE_W-1:0]       read_value,
    output logic [CHANNELS*(ADDR_W+1)-1:0]     read_address,
    output logic                               valid_pixel,
    output logic [7:0]                         r,
    output logic [7:0]                         g,
    output logic [7:0]                         b,
    output logic [CHANNELS-1:0]                channel_hit
);

    typedef enum logic [1:0] {
        MODE_LINE = 2'b00,
        MODE_DOT  = 2'b01,
        MODE_FILL = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    localparam int unsigned X_END = X_START + (32'd1 << (ADDR_W + 1));
    localparam logic [SAMPLE_W-1:0] FILL_BASE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                  active_index;
    mode_e                 active_mode;

    // stage 0
    logic [10:0]           win_x;
    logic                  in_win;
    logic [ADDR_W-1:0]     sample_idx;
    logic [ADDR_W-1:0]     last_idx;
    logic                  idx_chg;

    // stage 1
    logic                  in_win_q;
    logic [SAMPLE_W-1:0]   trans_y_q;
    logic                  y_ok_q;
    logic                  first_col_q;
    logic                  idx_chg_q;
    logic [SAMPLE_W-1:0]   cur      [CHANNELS];
    logic [SAMPLE_W-1:0]   prev     [CHANNELS];
    logic [SAMPLE_W-1:0]   prev_eff [CHANNELS];
    logic [CHANNELS-1:0]   cov;
    logic [CHANNELS-1:0]   hit;
    logic [23:0]           rgb_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_index <= 1'b0;
            active_mode  <= MODE_LINE;
        end else if (frame_start) begin
            active_index <= read_index;
            active_mode  <= mode_e'(mode);
        end
    end

    assign win_x      = x - 11'(X_START);
    assign in_win     = valid && (32'(x) >= X_START) && (32'(x) < X_END);
    assign sample_idx = in_win ? win_x[ADDR_W:1] : '0;
    assign idx_chg    = (sample_idx != last_idx);
    assign read_address = {CHANNELS{active_index, sample_idx}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_win_q    <= 1'b0;
            trans_y_q   <= '0;
            y_ok_q      <= 1'b0;
            first_col_q <= 1'b0;
            idx_chg_q   <= 1'b0;
            last_idx    <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) prev[c] <= '0;
        end else begin
            in_win_q    <= in_win;
            trans_y_q   <= y[SAMPLE_W:1];
            y_ok_q      <= ((y >> (SAMPLE_W + 1)) == '0);
            first_col_q <= (win_x == '0);
            idx_chg_q   <= idx_chg;
            last_idx    <= sample_idx;
            // RAM data for a new sample arrives one cycle after its address changed
            if (idx_chg_q) begin
                for (int unsigned c = 0; c < CHANNELS; c++) prev[c] <= cur[c];
            end
        end
    end

    always_comb begin
        cov = '0;
        hit = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            cur[c]      = read_value[c*SAMPLE_W +: SAMPLE_W];
            prev_eff[c] = first_col_q ? cur[c] : prev[c];
            case (active_mode)
                MODE_LINE: cov[c] = (prev_eff[c] <= cur[c])
                    ? (trans_y_q >= prev_eff[c] && trans_y_q <= cur[c])
                    : (trans_y_q >= cur[c] && trans_y_q <= prev_eff[c]);
                MODE_DOT:  cov[c] = (trans_y_q == cur[c]);
                MODE_FILL: cov[c] = (FILL_BASE <= cur[c])
                    ? (trans_y_q >= FILL_BASE && trans_y_q <= cur[c])
                    : (trans_y_q >= cur[c] && trans_y_q <= FILL_BASE);
                default:   cov[c] = 1'b0;
            endcase
            hit[c] = cov[c] && in_win_q && y_ok_q;
        end
    end

    // walk from the highest channel down so the lowest-indexed hit wins
    always_comb begin
        rgb_next = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (hit[CHANNELS-1-i]) rgb_next = COLORS[(CHANNELS-1-i)*24 +: 24];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            channel_hit <= '0;
            valid_pixel <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            channel_hit <= hit;
            valid_pixel <= |hit;
            {r, g, b}   <= rgb_next;
        end
    end

endmodule

// File: tb/tb_wave_display_multi.sv
// Self-checking bench for wave_display_multi: directed scenarios plus random scans
// compared against a pixel-level reference model with a modelled 1-cycle-latency RAM.
module tb_wave_display_multi;

    localparam logic [47:0] COLS = {24'hFFFF00, 24'h00FFFF};

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        frame_start;
    logic        read_index;
    logic [1:0]  mode;
    logic [10:0] x;
    logic [9:0]  y;
    logic [15:0] read_value;
    logic [17:0] read_address;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic [1:0]  channel_hit;

    wave_display_multi #(
        .CHANNELS(2), .ADDR_W(8), .SAMPLE_W(8), .X_START(256),
        .COLORS({24'hFFFF00, 24'h00FFFF})
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .frame_start(frame_start),
        .read_index(read_index), .mode(mode), .x(x), .y(y),
        .read_value(read_value), .read_address(read_address),
        .valid_pixel(valid_pixel), .r(r), .g(g), .b(b), .channel_hit(channel_hit)
    );

    always #5 clk = ~clk;

    // per-channel dual-buffer sample RAM, synchronous read
    logic [7:0] mem [2][2][256];
    always @(posedge clk) begin
        read_value[7:0]  <= mem[0][read_address[8]][read_address[7:0]];
        read_value[15:8] <= mem[1][read_address[17]][read_address[16:9]];
    end

    typedef struct {
        logic [1:0]  hit;
        logic        vp;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vp_count = 0;

    // reference state: latched frame settings, sample index of previous cycle and
    // the sample value that started the previous run of equal indices
    logic       m_idx;
    logic [1:0] m_mode;
    int         m_last;
    int         m_prev [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit covers(input logic [1:0] md, input int t, input int p, input int c);
        int lo, hi;
        case (md)
            2'b00: begin lo = (p < c) ? p : c; hi = (p < c) ? c : p; return t >= lo && t <= hi; end
            2'b01: return t == c;
            2'b10: begin lo = (c < 128) ? c : 128; hi = (c < 128) ? 128 : c; return t >= lo && t <= hi; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_idx = 1'b0; m_mode = 2'b00; m_last = 0;
        m_prev[0] = 0; m_prev[1] = 0;
        exp_q.delete();
    endtask

    // one pixel cycle; entered and left at posedge+1
    task automatic tick(input bit v, input int xi, input int yi,
                        input bit fs, input bit ri, input logic [1:0] md);
        bit   win, yok, first;
        int   sidx, t, pv;
        int   cur [2];
        exp_t e, o;
        valid = v; x = 11'(xi); y = 10'(yi);
        frame_start = fs; read_index = ri; mode = md;
        win  = v && xi >= 256 && xi < 768;
        sidx = win ? (xi - 256) / 2 : 0;
        #1;
        check("read_address", 32'(read_address), 32'({m_idx, 8'(sidx), m_idx, 8'(sidx)}));
        for (int c = 0; c < 2; c++) cur[c] = int'(mem[c][m_idx][sidx]);
        if (fs) begin m_idx = ri; m_mode = md; end
        t = (yi / 2) % 256; yok = yi < 512; first = (xi == 256);
        e.hit = '0;
        for (int c = 0; c < 2; c++) begin
            pv = first ? cur[c] : m_prev[c];
            e.hit[c] = win && yok && covers(m_mode, t, pv, cur[c]);
        end
        e.vp  = |e.hit;
        e.rgb = e.hit[0] ? COLS[23:0] : (e.hit[1] ? COLS[47:24] : 24'h0);
        if (sidx != m_last) begin m_prev[0] = cur[0]; m_prev[1] = cur[1]; end
        m_last = sidx;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (exp_q.size() >= 2) begin
            o = exp_q.pop_front();
            if (valid_pixel === 1'b1) vp_count++;
            check("valid_pixel", 32'(valid_pixel), 32'(o.vp));
            check("rgb", 32'({r, g, b}), 32'(o.rgb));
            check("channel_hit", 32'(channel_hit), 32'(o.hit));
        end
    endtask

    task automatic frame(input bit ri, input logic [1:0] md);
        tick(1'b0, 0, 0, 1'b1, ri, md);
    endtask

    task automatic scan(input int x0, input int x1, input int yi);
        for (int xi = x0; xi <= x1; xi++) tick(1'b1, xi, yi, 1'b0, 1'b0, 2'b00);
    endtask

    // asynchronous reset from posedge+1; outputs checked before any clock edge
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_valid_pixel", 32'(valid_pixel), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_channel_hit", 32'(channel_hit), 32'd0);
        valid = 1'b0; frame_start = 1'b0; x = '0; y = '0;
        @(posedge clk); #3 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("rst_read_address", 32'(read_address), 32'd0);
    endtask

    task automatic fill_mem(input int ch, input int half, input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[ch][half][i] = v;
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; frame_start = 1'b0; read_index = 1'b0;
        mode = 2'b00; x = '0; y = '0;
        for (int c = 0; c < 2; c++) for (int h = 0; h < 2; h++) fill_mem(c, h, 8'h00);
        model_reset();
        @(posedge clk); #1;
        async_reset();

        // flat traces: whole window lit, channel 0 colour wins
        fill_mem(0, 0, 8'h40); fill_mem(1, 0, 8'h40);
        frame(1'b0, 2'b00);
        vp_count = 0;
        scan(250, 775, 10'h080);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 2'b00);
        check("flat_pixel_count", 32'(vp_count), 32'd512);

        // async reset while pixels are being drawn
        scan(256, 270, 10'h080);
        check("pre_reset_vp", 32'(valid_pixel), 32'd1);
        async_reset();

        // step between samples 5 and 6 on channel 0
        for (int i = 0; i < 256; i++) mem[0][0][i] = (i <= 5) ? 8'h10 : 8'h30;
        fill_mem(1, 0, 8'hFF);
        frame(1'b0, 2'b00);
        foreach (y[i]) ;
        scan(250, 280, 2 * 8'h10);
        scan(250, 280, 2 * 8'h20);
        scan(250, 280, 2 * 8'h30);
        scan(250, 280, 2 * 8'h0F);
        scan(250, 280, 2 * 8'h31);

        // left edge directly after a full line ending in a low sample
        fill_mem(0, 0, 8'h20);
        mem[0][0][0] = 8'h70; mem[0][0][255] = 8'h00;
        frame(1'b0, 2'b00);
        scan(256, 767, 2 * 8'h38);
        scan(256, 262, 2 * 8'h38);
        scan(256, 767, 2 * 8'h70);
        scan(256, 262, 2 * 8'h70);

        // dot, fill and off modes around a single sample
        fill_mem(0, 0, 8'h20); mem[0][0][3] = 8'h90;
        for (int md = 1; md < 4; md++) begin
            frame(1'b0, 2'(md));
            scan(256, 270, 2 * 8'h90);
            scan(256, 270, 2 * 8'h85);
            scan(256, 270, 2 * 8'h80);
            scan(256, 270, 2 * 8'h7F);
            scan(256, 270, 2 * 8'h91 + 1);
        end

        // buffer/mode changes take effect only at frame_start
        fill_mem(0, 1, 8'h55); fill_mem(1, 1, 8'h66);
        frame(1'b0, 2'b00);
        scan(256, 266, 2 * 8'h20);
        for (int xi = 267; xi < 280; xi++) tick(1'b1, xi, 2 * 8'h20, 1'b0, 1'b1, 2'b01);
        check("latch_hold_msb", 32'(read_address[17]), 32'd0);
        frame(1'b1, 2'b00);
        scan(256, 280, 2 * 8'h55);
        check("latch_new_msb", 32'(read_address[8]), 32'd1);

        // random data, frame settings, rows and blanking
        for (int c = 0; c < 2; c++) for (int h = 0; h < 2; h++)
            for (int i = 0; i < 256; i++) mem[c][h][i] = 8'($urandom_range(0, 255));
        for (int ln = 0; ln < 30; ln++) begin
            int yi;
            if ($urandom_range(0, 1) == 1)
                frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            yi = ($urandom_range(0, 19) == 0) ? $urandom_range(512, 1023) : $urandom_range(0, 511);
            for (int xi = 240; xi < 790; xi++) begin
                bit fs;
                fs = ($urandom_range(0, 299) == 0);
                tick(1'($urandom_range(0, 15) != 0), xi, yi, fs,
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
        end

        async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
